aq_djpeg_srcfifo: RTL and testbench
===================================

Name: aq_djpeg_srcfifo

Overview:
Byte-to-word source buffer that feeds the JPEG decoder's 32-bit input port. It accepts the compressed JPEG byte stream from the storage/SPI reader and packs it MSB-first into 32-bit words. The words are held in a show-ahead FIFO and handed to the decoder through the DataIn/DataInEnable/DataInRead handshake. It also tracks end-of-stream and reports completion once the decoder has consumed the final word.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth in 32-bit words (depth = 16).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
Flush  input  1  synchronous clear of packer, FIFO and status (one-cycle pulse)
ByteIn  input  8  JPEG byte from the stream reader
ByteInValid  input  1  ByteIn is valid this cycle
ByteInLast  input  1  qualifies ByteIn as the final byte of the file
ByteInReady  output  1  block accepts a byte this cycle
DataOut  output  32  head-of-FIFO word; connects to the decoder DataIn
DataOutEnable  output  1  FIFO non-empty; connects to the decoder DataInEnable
DataOutRead  input  1  decoder pops the head word; from the decoder DataInRead
Level  output  DEPTH_LOG2+1  number of words currently stored
Done  output  1  last word of the stream has been read
Underrun  output  1  sticky: DataOutRead seen while FIFO empty

Behaviour:
- Reset (rst=0, async) and Flush (sync, next edge): ByteInReady=0 during reset, then 1; DataOut=0; DataOutEnable=0; Level=0; Done=0; Underrun=0; packer count=0; ended=0. Flush takes priority over any same-cycle byte or read, which are discarded.
- Byte accept: occurs when ByteInValid & ByteInReady.
- ByteInReady = !ended & (Level < 2^DEPTH_LOG2). It is registered or derived from registers only, with no combinational path from DataOutRead.
- Packer: a 2-bit count plus a 24-bit holding register. The first byte of each word goes to [31:24], then [23:16], [15:8], [7:0].
- An accepted byte with count==3 writes the assembled word to the FIFO in the same edge; count wraps to 0.
- An accepted byte with ByteInLast:
  - writes the word immediately regardless of count, padding the unfilled low bytes with 0x00;
  - sets ended=1, which holds ByteInReady=0 until Flush;
  - count returns to 0.
- A Last byte that lands exactly on count==3 produces one word only; no extra pad word.
- FIFO: show-ahead. DataOut always shows the head word while DataOutEnable=1.
  - A word written at edge N is visible, with DataOutEnable=1, after edge N (first-word latency 1 cycle).
  - DataOutRead & DataOutEnable pops the head; the next word is visible the following cycle.
  - Simultaneous write and pop: Level unchanged, order preserved. Writing while full cannot occur because ByteInReady=0.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - Level = write count minus read count, range 0..2^DEPTH_LOG2.
- Read when empty: no pop; Level stays 0; DataOut unchanged; Underrun<=1 (sticky until reset/Flush).
- Done<=1 on the edge where ended=1 and the pop empties the FIFO (Level 1->0). Done also asserts if ended=1 and Level==0 after the final write has been consumed. It holds until Flush/reset.
- Reset mid-operation discards all buffered data; no partial word is emitted.

Test Plan:
- Bytes FF D8 FF E0 00 10 4A 46 with no Last, no reads -> Level=2. Head DataOut=32'hFFD8FFE0; after one DataOutRead, DataOut=32'h00104A46 next cycle.
- Bytes FF D9 17 with Last on 0x17 -> one word 32'hFFD91700; ByteInReady=0 afterwards. Reading it -> Done=1 and DataOutEnable=0 the next cycle.
- Bytes 01 02 03 04 with Last on 0x04 -> exactly one word 32'h01020304, Level=1. After the read, Done=1 and no second word appears.
- Continuous byte stream, no reads -> after 64 bytes Level=16 and ByteInReady=0. A single read drops Level to 15 and ByteInReady returns to 1. Continued random stalls and reads across many pointer wraps -> data matches the stream in order.
- DataOutRead pulsed with FIFO empty -> Underrun=1, Level=0. Flush -> Underrun=0, Done=0, ByteInReady=1, and the partial packer contents are dropped (the next word starts at [31:24]).
- Assert rst=0 asynchronously mid-word with Level=5 -> outputs clear immediately (Level=0, DataOutEnable=0, Done=0). After release, a fresh 4-byte input yields a correctly aligned word.

Source files
------------

// File: rtl/aq_djpeg_srcfifo.sv
// aq_djpeg_srcfifo
//   Byte-to-word source buffer for the JPEG decoder input port. Incoming
//   stream bytes are packed MSB-first into 32-bit words and queued in a
//   show-ahead FIFO that the decoder drains through DataOut/DataOutEnable/
//   DataOutRead. End-of-stream is tracked so Done can report that the last
//   word has been consumed.
//
// Handshakes:
//   Byte side : a byte transfers on a rising edge where ByteInValid and
//               ByteInReady are both 1. ByteInReady comes from registers only.
//   Word side : DataOut is valid whenever DataOutEnable is 1; a word is popped
//               on a rising edge where DataOutRead and DataOutEnable are both
//               1. DataOutRead while empty pops nothing and sets Underrun.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   Flush               synchronous clear of everything, wins over traffic
//   ByteIn/ByteInValid/ByteInLast/ByteInReady   byte input stream
//   DataOut/DataOutEnable/DataOutRead           decoder word interface
//   Level               words currently stored (0..2^DEPTH_LOG2)
//   Done                final word of the stream has been read (sticky)
//   Underrun            read attempted while empty (sticky)
module aq_djpeg_srcfifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Flush,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteInValid,
  input  logic                  ByteInLast,
  output logic                  ByteInReady,
  output logic [31:0]           DataOut,
  output logic                  DataOutEnable,
  input  logic                  DataOutRead,
  output logic [DEPTH_LOG2:0]   Level,
  output logic                  Done,
  output logic                  Underrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2:0]   level_next;
  logic [1:0]            count;
  logic [23:0]           hold;
  logic                  ended;
  logic                  ended_next;
  logic                  started;
  logic                  done;
  logic                  underrun;

  logic                  empty;
  logic                  full;
  logic                  ready;
  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;
  logic [31:0]           word;

  assign empty  = (level == '0);
  assign full   = (level == (DEPTH_LOG2 + 1)'(DEPTH));
  // started keeps ready low while reset is asserted and for the edge it
  // releases on, so ready is never derived from the reset pin itself.
  assign ready  = started & ~ended & ~full;
  assign accept = ByteInValid & ready;
  // A Last byte closes the word early; unfilled low bytes of hold are
  // already zero, which provides the 0x00 padding.
  assign wr_en  = accept & ((count == 2'd3) | ByteInLast);
  assign rd_en  = DataOutRead & ~empty;
  assign ended_next = ended | (accept & ByteInLast);

  always_comb begin
    word = {hold, 8'h00};
    case (count)
      2'd0:    word[31:24] = ByteIn;
      2'd1:    word[23:16] = ByteIn;
      2'd2:    word[15:8]  = ByteIn;
      default: word[7:0]   = ByteIn;
    endcase
  end

  always_comb begin
    level_next = level;
    if (wr_en && !rd_en)      level_next = level + 1'b1;
    else if (rd_en && !wr_en) level_next = level - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      count    <= 2'd0;
      hold     <= 24'h0;
      ended    <= 1'b0;
      started  <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      started <= 1'b1;
      if (Flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        count    <= 2'd0;
        hold     <= 24'h0;
        ended    <= 1'b0;
        done     <= 1'b0;
        underrun <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        level <= level_next;
        ended <= ended_next;
        if (DataOutRead && empty) underrun <= 1'b1;
        if (ended_next && (level_next == '0)) done <= 1'b1;
        if (accept) begin
          if (wr_en) begin
            count <= 2'd0;
            hold  <= 24'h0;
          end else begin
            count <= count + 2'd1;
            case (count)
              2'd0:    hold[23:16] <= ByteIn;
              2'd1:    hold[15:8]  <= ByteIn;
              default: hold[7:0]   <= ByteIn;
            endcase
          end
        end
      end
    end
  end

  // Storage array carries no reset; only entries between the pointers are
  // ever observable.
  always_ff @(posedge clk) begin
    if (wr_en && !Flush) mem[wr_ptr] <= word;
  end

  assign ByteInReady   = ready;
  assign DataOut       = empty ? 32'h0 : mem[rd_ptr];
  assign DataOutEnable = ~empty;
  assign Level         = level;
  assign Done          = done;
  assign Underrun      = underrun;

endmodule

// File: tb/tb_aq_djpeg_srcfifo.sv
module tb_aq_djpeg_srcfifo;

  logic        clk;
  logic        rst;
  logic        Flush;
  logic [7:0]  ByteIn;
  logic        ByteInValid;
  logic        ByteInLast;
  logic        ByteInReady;
  logic [31:0] DataOut;
  logic        DataOutEnable;
  logic        DataOutRead;
  logic [4:0]  Level;
  logic        Done;
  logic        Underrun;

  aq_djpeg_srcfifo #(.DEPTH_LOG2(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .Flush         (Flush),
    .ByteIn        (ByteIn),
    .ByteInValid   (ByteInValid),
    .ByteInLast    (ByteInLast),
    .ByteInReady   (ByteInReady),
    .DataOut       (DataOut),
    .DataOutEnable (DataOutEnable),
    .DataOutRead   (DataOutRead),
    .Level         (Level),
    .Done          (Done),
    .Underrun      (Underrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counters
  int n_vec = 0;
  int n_err = 0;

  // reference model: a queue of whole words plus the word being assembled
  logic [31:0] exp_q[$];
  logic [31:0] pend_word;
  int          pend_n;
  bit          m_ended;
  bit          m_done;
  bit          m_underrun;
  bit          m_started;
  bit          m_fresh;

  task automatic model_clear(input bit full_reset);
    exp_q.delete();
    pend_word  = 32'h0;
    pend_n     = 0;
    m_ended    = 1'b0;
    m_done     = 1'b0;
    m_underrun = 1'b0;
    m_fresh    = 1'b1;
    if (full_reset) m_started = 1'b0;
  endtask

  function automatic bit m_ready();
    return m_started && !m_ended && (exp_q.size() < 16);
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] b, input logic l,
                            input logic r, input logic f);
    bit acc;
    if (f) begin
      model_clear(1'b0);
    end else begin
      acc = v && m_ready();
      if (r) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else m_underrun = 1'b1;
      end
      if (acc) begin
        pend_word = pend_word | (32'(b) << (24 - 8 * pend_n));
        pend_n++;
        if (pend_n == 4 || l) begin
          exp_q.push_back(pend_word);
          m_fresh   = 1'b0;
          pend_word = 32'h0;
          pend_n    = 0;
          if (l) m_ended = 1'b1;
        end
      end
      if (m_ended && exp_q.size() == 0) m_done = 1'b1;
    end
    m_started = 1'b1;
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("level", 32'(Level), 32'(exp_q.size()));
    chk("enable", 32'(DataOutEnable), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("dataout", DataOut, exp_q[0]);
    else if (m_fresh) chk("dataout_idle", DataOut, 32'h0);
    chk("ready", 32'(ByteInReady), 32'(m_ready()));
    chk("done", 32'(Done), 32'(m_done));
    chk("underrun", 32'(Underrun), 32'(m_underrun));
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic step(input logic v, input logic [7:0] b, input logic l,
                      input logic r, input logic f);
    check_outputs();
    ByteInValid = v;
    ByteIn      = b;
    ByteInLast  = l;
    DataOutRead = r;
    Flush       = f;
    @(posedge clk);
    model_edge(v, b, l, r, f);
    @(negedge clk);
    ByteInValid = 1'b0;
    ByteIn      = 8'h00;
    ByteInLast  = 1'b0;
    DataOutRead = 1'b0;
    Flush       = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    step(1'b1, b, l, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  logic [7:0] seq8 [8] = '{8'hFF, 8'hD8, 8'hFF, 8'hE0, 8'h00, 8'h10, 8'h4A, 8'h46};

  initial begin
    rst = 1'b0; Flush = 1'b0; ByteIn = 8'h00; ByteInValid = 1'b0;
    ByteInLast = 1'b0; DataOutRead = 1'b0;
    model_clear(1'b1);

    // reset state
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    idle();
    idle();
    chk("rst_ready_after", 32'(ByteInReady), 32'd1);

    // two words, MSB-first packing, show-ahead pop
    for (int i = 0; i < 8; i++) send(seq8[i], 1'b0);
    idle();
    chk("tp1_level", 32'(Level), 32'd2);
    chk("tp1_head0", DataOut, 32'hFFD8FFE0);
    rd();
    chk("tp1_head1", DataOut, 32'h00104A46);
    rd();
    idle();

    // short final word is padded, input closes, Done after the read
    flush();
    send(8'hFF, 1'b0); send(8'hD9, 1'b0); send(8'h17, 1'b1);
    idle();
    chk("tp2_word", DataOut, 32'hFFD91700);
    chk("tp2_ready", 32'(ByteInReady), 32'd0);
    send(8'hAA, 1'b0);
    rd();
    chk("tp2_done", 32'(Done), 32'd1);
    chk("tp2_enable", 32'(DataOutEnable), 32'd0);
    idle();

    // Last landing on a full word yields a single word
    flush();
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
    idle();
    chk("tp3_level", 32'(Level), 32'd1);
    chk("tp3_word", DataOut, 32'h01020304);
    rd();
    chk("tp3_done", 32'(Done), 32'd1);
    idle(); idle();
    chk("tp3_no_pad", 32'(Level), 32'd0);

    // fill to capacity, then one read reopens the input
    flush();
    for (int i = 0; i < 64; i++) send(8'($urandom_range(0, 255)), 1'b0);
    chk("tp4_full_level", 32'(Level), 32'd16);
    chk("tp4_full_ready", 32'(ByteInReady), 32'd0);
    send(8'h5A, 1'b0);
    rd();
    chk("tp4_level15", 32'(Level), 32'd15);
    chk("tp4_ready_back", 32'(ByteInReady), 32'd1);

    // random traffic across many pointer wraps
    for (int i = 0; i < 1800; i++) begin
      int rp;
      case ((i / 300) % 3)
        0:       rp = 25;
        1:       rp = 55;
        default: rp = 85;
      endcase
      step(($urandom_range(0, 99) < 70), 8'($urandom_range(0, 255)), 1'b0,
           ($urandom_range(0, 99) < rp), 1'b0);
    end
    // close the stream with a partial word and drain
    send(8'hC3, 1'b0);
    send(8'h9E, 1'b1);
    for (int i = 0; i < 20; i++) rd();
    chk("rand_done", 32'(Done), 32'd1);

    // underrun, then flush drops partial packer contents
    flush();
    rd();
    chk("tp5_underrun", 32'(Underrun), 32'd1);
    chk("tp5_level", 32'(Level), 32'd0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b1);
    chk("tp5_flush_underrun", 32'(Underrun), 32'd0);
    chk("tp5_flush_done", 32'(Done), 32'd0);
    chk("tp5_flush_ready", 32'(ByteInReady), 32'd1);
    chk("tp5_flush_level", 32'(Level), 32'd0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    idle();
    chk("tp5_aligned", DataOut, 32'h11223344);

    // asynchronous reset mid-word
    flush();
    for (int i = 0; i < 22; i++) send(8'(i + 1), 1'b0);
    chk("tp6_level5", 32'(Level), 32'd5);
    #2 rst = 1'b0;
    #1;
    model_clear(1'b1);
    chk("tp6_rst_level", 32'(Level), 32'd0);
    chk("tp6_rst_enable", 32'(DataOutEnable), 32'd0);
    chk("tp6_rst_done", 32'(Done), 32'd0);
    chk("tp6_rst_ready", 32'(ByteInReady), 32'd0);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    idle();
    send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b0);
    idle();
    chk("tp6_aligned", DataOut, 32'hDEADBEEF);
    chk("tp6_level1", 32'(Level), 32'd1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
